// File: rtl/ascon_pack.sv
// ascon_pack: shared Ascon state type, controller FSM encoding and round constants.
package ascon_pack;
    typedef logic [4:0][63:0] type_state;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} fsm_e;
    localparam logic [3:0] LAST_ROUND = 4'd11;
    // Entry r is ((15-r)<<4)|r.
    localparam logic [11:0][7:0] ROUND_CONSTANTS = {
        8'h4b, 8'h5a, 8'h69, 8'h78, 8'h87, 8'h96,
        8'ha5, 8'hb4, 8'hc3, 8'hd2, 8'he1, 8'hf0
    };
    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction
endpackage

// File: rtl/permutation_round.sv
// permutation_round: one combinational Ascon round (constant, bitsliced S-box, linear layer).
module permutation_round
    import ascon_pack::*;
(
    input  type_state  state_i,
    input  logic [7:0] rc_i,
    output type_state  state_o
);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    always_comb begin
        x0 = state_i[0];
        x1 = state_i[1];
        x2 = state_i[2] ^ {56'd0, rc_i};
        x3 = state_i[3];
        x4 = state_i[4];
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        state_o[0] = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        state_o[1] = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        state_o[2] = x2 ^ ror64(x2, 1) ^ ror64(x2, 6);
        state_o[3] = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        state_o[4] = x4 ^ ror64(x4, 7) ^ ror64(x4, 41);
    end
endmodule

// File: rtl/ascon_permutation_ctrl.sv
// ascon_permutation_ctrl: iterates the Ascon round one per cycle for p^a / p^b requests.
module ascon_permutation_ctrl
    import ascon_pack::*;
#(
    parameter int NB_ROUNDS_A = 12,
    parameter int NB_ROUNDS_B = 6
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       mode_i,
    input  type_state  state_i,
    output logic       ready_o,
    output logic       done_o,
    output logic [3:0] round_o,
    output type_state  state_o
);
    localparam logic [3:0] FIRST_A = 4'(12 - NB_ROUNDS_A);
    localparam logic [3:0] FIRST_B = 4'(12 - NB_ROUNDS_B);

    fsm_e       fsm_q, fsm_d;
    logic [3:0] cnt_q, cnt_d;
    type_state  state_q, state_d, round_state;

    permutation_round u_round (
        .state_i(state_q),
        .rc_i   (ROUND_CONSTANTS[cnt_q]),
        .state_o(round_state)
    );

    // A start is honoured from both IDLE and DONE, which gives back-to-back issue.
    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (fsm_q == RUN) begin
            state_d = round_state;
            cnt_d   = (cnt_q == LAST_ROUND) ? 4'd0 : cnt_q + 4'd1;
            fsm_d   = (cnt_q == LAST_ROUND) ? DONE : RUN;
        end else if (start_i) begin
            state_d = state_i;
            cnt_d   = mode_i ? FIRST_B : FIRST_A;
            fsm_d   = RUN;
        end else begin
            fsm_d = IDLE;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q   <= IDLE;
            cnt_q   <= 4'd0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign ready_o = (fsm_q != RUN);
    assign done_o  = (fsm_q == DONE);
    assign round_o = (fsm_q == RUN) ? cnt_q : 4'd0;
    assign state_o = state_q;
endmodule

// File: tb/tb_ascon_permutation_ctrl.sv
// tb_ascon_permutation_ctrl: table-driven and randomized checks against an S-box-table Ascon model.
module tb_ascon_permutation_ctrl;
    import ascon_pack::*;

    localparam int NA = 12;
    localparam int NB = 6;
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    localparam int RA [5] = '{19, 61, 1, 10, 7};
    localparam int RB [5] = '{28, 39, 6, 17, 41};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic       mode_i = 1'b0;
    type_state  state_i = '0;
    logic       ready_o, done_o;
    logic [3:0] round_o;
    type_state  state_o;
    type_state  rnd_in = '0;
    logic [7:0] rnd_rc = 8'h00;
    type_state  rnd_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ascon_permutation_ctrl #(.NB_ROUNDS_A(NA), .NB_ROUNDS_B(NB)) dut (
        .clock_i(clk),
        .reset_i(rst),
        .start_i(start_i),
        .mode_i (mode_i),
        .state_i(state_i),
        .ready_o(ready_o),
        .done_o (done_o),
        .round_o(round_o),
        .state_o(state_o)
    );

    permutation_round u_rnd (.state_i(rnd_in), .rc_i(rnd_rc), .state_o(rnd_out));

    typedef struct {
        logic       start;
        logic       mode;
        logic       acc;
        logic       exp_ready;
        logic       exp_done;
        logic [3:0] exp_round;
    } step_t;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic type_state model_round(input type_state s, input int r);
        type_state  n;
        logic [4:0] v;
        s[2][7:0] = s[2][7:0] ^ 8'(((15 - r) << 4) | r);
        for (int b = 0; b < 64; b++) begin
            v = SBOX[{s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]}];
            {n[0][b], n[1][b], n[2][b], n[3][b], n[4][b]} = v;
        end
        for (int i = 0; i < 5; i++) n[i] = n[i] ^ ror(n[i], RA[i]) ^ ror(n[i], RB[i]);
        return n;
    endfunction

    function automatic type_state model_perm(input type_state s, input int first);
        for (int r = first; r < 12; r++) s = model_round(s, r);
        return s;
    endfunction

    function automatic type_state rand_state();
        type_state s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input logic mode, input type_state s, input bit noise);
        int n, first, lat;
        n = mode ? NB : NA;
        first = 12 - n;
        state_i = s;
        mode_i = mode;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("first_round", round_o, first);
        check("ready_in_run", ready_o, 1'b0);
        lat = 0;
        while (!done_o && lat < 40) begin
            if (noise) begin
                start_i = 1'($urandom);
                mode_i = 1'($urandom);
                state_i = rand_state();
            end
            tick();
            lat++;
            if (!done_o && lat < n) check("round_seq", round_o, first + lat);
        end
        start_i = 1'b0;
        check("latency", lat, n);
        check("result", state_o, model_perm(s, first));
        check("ready_done", ready_o, 1'b1);
    endtask

    initial begin
        step_t     steps [16];
        type_state acc_state, last_res, iv;
        int        k, seen_done;
        steps[0]  = '{1, 1, 1, 0, 0, 6};
        steps[1]  = '{1, 0, 0, 0, 0, 7};
        steps[2]  = '{1, 1, 0, 0, 0, 8};
        steps[3]  = '{1, 0, 0, 0, 0, 9};
        steps[4]  = '{1, 0, 0, 0, 0, 10};
        steps[5]  = '{1, 1, 0, 0, 0, 11};
        steps[6]  = '{1, 0, 0, 1, 1, 0};
        steps[7]  = '{1, 1, 1, 0, 0, 6};
        steps[8]  = '{1, 0, 0, 0, 0, 7};
        steps[9]  = '{1, 1, 0, 0, 0, 8};
        steps[10] = '{1, 0, 0, 0, 0, 9};
        steps[11] = '{1, 1, 0, 0, 0, 10};
        steps[12] = '{1, 0, 0, 0, 0, 11};
        steps[13] = '{1, 0, 0, 1, 1, 0};
        steps[14] = '{0, 0, 0, 1, 0, 0};
        steps[15] = '{0, 1, 0, 1, 0, 0};
        iv = '0;
        iv[0] = 64'h80400c0600000000;

        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", ready_o, 1'b1);
        check("rst_done", done_o, 1'b0);
        check("rst_round", round_o, 4'd0);
        check("rst_state", state_o, '0);

        rnd_in = '0;
        rnd_rc = 8'hf0;
        #1;
        check("single_round0", rnd_out, model_round('0, 0));

        run_txn(1'b0, iv, 1'b0);
        tick();
        run_txn(1'b1, iv, 1'b0);
        tick();

        acc_state = '0;
        last_res = state_o;
        for (int i = 0; i < 16; i++) begin
            start_i = steps[i].start;
            mode_i = steps[i].mode;
            state_i = rand_state();
            if (steps[i].acc) acc_state = state_i;
            tick();
            check("tbl_ready", ready_o, steps[i].exp_ready);
            check("tbl_done", done_o, steps[i].exp_done);
            check("tbl_round", round_o, steps[i].exp_round);
            if (steps[i].exp_done) begin
                last_res = model_perm(acc_state, 12 - NB);
                check("tbl_result", state_o, last_res);
            end else if (steps[i].exp_ready) begin
                check("tbl_hold", state_o, last_res);
            end
        end
        start_i = 1'b0;

        for (int t = 0; t < 20; t++) begin
            run_txn(1'($urandom), rand_state(), 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
        state_i = rand_state();
        mode_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        k = 0;
        while (round_o != 4'd5 && k < 20) begin
            tick();
            k++;
        end
        check("abort_round5", round_o, 4'd5);
        rst = 1'b1;
        start_i = 1'b1;
        tick();
        rst = 1'b0;
        start_i = 1'b0;
        check("abort_ready", ready_o, 1'b1);
        check("abort_done", done_o, 1'b0);
        check("abort_round", round_o, 4'd0);
        check("abort_state", state_o, '0);
        seen_done = 0;
        repeat (14) begin
            tick();
            if (done_o) seen_done++;
        end
        check("abort_no_done", seen_done, 0);
        run_txn(1'b0, iv, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
